mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose the following parameters: ADDR_W, default 32, address width; LINE_W, default 128, cache-line width; TIMEOUT, default 255, maximum number of BUSY cycles spent waiting for mem_ready.
REQ-002 The block SHALL have exactly one clock and a synchronous, active-low reset, with ports as follows: clk (in, 1); rst_n (in, 1).
REQ-003 The data-cache port SHALL be: d_req in 1, level request; d_we in 1, 1=write 0=read; d_addr in ADDR_W; d_wdata in LINE_W; d_rdata out LINE_W; d_done out 1, one-cycle completion pulse; d_err out 1, timeout flag valid with d_done.
REQ-004 The instruction-cache port SHALL be read-only: i_req in 1; i_addr in ADDR_W; i_rdata out LINE_W; i_done out 1; i_err out 1.
REQ-005 The memory port SHALL be: mem_rd out 1; mem_wr out 1; mem_addr out ADDR_W; mem_wdata out LINE_W; mem_rdata in LINE_W; mem_ready in 1.
REQ-006 The block SHALL provide busy out 1, which is high whenever the state is not IDLE.

Function
REQ-007 The FSM SHALL have three states: IDLE, BUSY and DONE; all outputs SHALL be registered.
REQ-008 In IDLE with no request pending, the state SHALL remain IDLE, and mem_rd and mem_wr SHALL be 0.
REQ-009 In IDLE with exactly one request pending, that port SHALL be granted.
REQ-010 In IDLE with both d_req and i_req high, the port not recorded in last_grant SHALL be granted (round-robin).
REQ-011 last_grant SHALL reset to instr, so that the data port wins the first tie.
REQ-012 On a grant, the block SHALL latch grant, we, address and wdata, SHALL set last_grant, and SHALL enter BUSY at the next edge.
REQ-013 mem_rd (grant is instr, or data with d_we=0) or mem_wr (data with d_we=1) SHALL assert at that same edge.
REQ-014 mem_addr SHALL equal the latched address with bits [3:0] forced to 0 (16-byte line alignment).
REQ-015 mem_wdata SHALL equal the latched d_wdata during data writes and 0 otherwise.
REQ-016 In BUSY, mem_rd, mem_wr, mem_addr and mem_wdata SHALL stay constant until mem_ready is sampled high; requester inputs SHALL be ignored.
REQ-017 When mem_ready is sampled high in BUSY, the block SHALL, at the same edge: capture mem_rdata into the granted port's rdata (reads only; writes leave d_rdata unchanged); clear mem_rd and mem_wr; enter DONE; and assert the granted port's done pulse with err=0.
REQ-018 A BUSY cycle counter SHALL reset to 0 on entry to BUSY and increment each cycle mem_ready is low.
REQ-019 When the counter equals TIMEOUT-1 while mem_ready is still low, the block SHALL clear mem_rd and mem_wr, enter DONE, pulse done with err=1, and leave rdata unchanged.
REQ-020 A mem_ready arriving in the same cycle as the timeout condition SHALL take precedence and complete normally.
REQ-021 DONE SHALL last exactly one cycle and then go to IDLE; done and err SHALL be high only in DONE.
REQ-022 Requests SHALL NOT be sampled in DONE.
REQ-023 Requesters deassert req in the cycle after they observe done; a req still high in IDLE SHALL be treated as a new request.
REQ-024 Minimum latency SHALL be: req sampled at edge 0, mem_ready sampled at edge 1, done high after edge 1; this gives a 3-cycle turnaround per access.
REQ-025 mem_ready sampled high in IDLE or DONE SHALL be ignored.
REQ-026 The counter SHALL be sized as clog2(TIMEOUT+1) bits and SHALL never wrap.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL set: state IDLE; mem_rd=0, mem_wr=0; mem_addr=0, mem_wdata=0; d_done, i_done, d_err, i_err = 0; d_rdata=0, i_rdata=0; busy=0; counter 0; last_grant=instr.
REQ-028 A reset asserted in BUSY or DONE SHALL abort the access without producing any done pulse; mem strobes SHALL drop after that edge.

Verification
REQ-029 Single data read: d_req=1, d_we=0, d_addr=0x0000_1234; mem_ready high 3 cycles after mem_rd -> mem_addr=0x0000_1230, mem_rd high for 3 cycles, d_rdata=mem_rdata, d_done pulses once, d_err=0.
REQ-030 Simultaneous requests after reset, each held until served: d_req=i_req=1 -> data granted first, instr granted second; a second simultaneous pair -> data first again, because last_grant=instr after the instruction access.
REQ-031 Data write: d_we=1, d_wdata=0xDEADBEEF_..._0001 -> mem_wr=1, mem_wdata matches, d_rdata unchanged, d_done pulses.
REQ-032 Timeout with TIMEOUT=8 and mem_ready held low on an i_req -> mem_rd drops after 8 BUSY cycles, i_done=1 and i_err=1 for one cycle, i_rdata unchanged.
REQ-033 Reset mid-access: rst_n=0 during BUSY -> next edge mem_rd=0, busy=0, no done pulse; a subsequent request completes normally.
REQ-034 A stray mem_ready=1 in IDLE -> no done pulse, no rdata change.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter between a data-cache port (read/write)
//                and an instruction-cache port (read-only) sharing a single
//                line-wide memory port. IDLE/BUSY/DONE FSM, fully registered
//                outputs, BUSY-cycle timeout with error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    // data-cache port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    // instruction-cache port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_err,
    // memory port
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    // status
    output logic              busy
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [1:0]         c_IDLE     = 2'd0;
    localparam logic [1:0]         c_BUSY     = 2'd1;
    localparam logic [1:0]         c_DONE     = 2'd2;
    localparam logic               c_GNT_D    = 1'b0;
    localparam logic               c_GNT_I    = 1'b1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    // 16-byte line alignment: low nibble of the address is always cleared
    localparam logic [ADDR_W-1:0]  c_LINE_MASK = ~ADDR_W'(15);

    logic [1:0]         r_state, w_state_nxt;
    logic               r_gnt, w_gnt_nxt;
    logic               r_we, w_we_nxt;
    logic               r_last_gnt, w_last_gnt_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_mem_rd, w_mem_rd_nxt;
    logic               r_mem_wr, w_mem_wr_nxt;
    logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt;
    logic [LINE_W-1:0]  r_mem_wdata, w_mem_wdata_nxt;
    logic [LINE_W-1:0]  r_d_rdata, w_d_rdata_nxt;
    logic [LINE_W-1:0]  r_i_rdata, w_i_rdata_nxt;
    logic               r_d_done, w_d_done_nxt;
    logic               r_i_done, w_i_done_nxt;
    logic               r_d_err, w_d_err_nxt;
    logic               r_i_err, w_i_err_nxt;
    logic               r_busy, w_busy_nxt;

    logic               w_any_req;
    logic               w_pick_i;
    logic               w_new_we;
    logic               w_timeout;

    // Instruction port wins when it is the only requester, or on a tie when
    // the data port was served last.
    assign w_any_req = d_req | i_req;
    assign w_pick_i  = i_req & (~d_req | (r_last_gnt == c_GNT_D));
    assign w_new_we  = ~w_pick_i & d_we;
    // mem_ready in the same cycle overrides the timeout
    assign w_timeout = (r_cnt == c_CNT_LAST) & ~mem_ready;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_gnt       <= c_GNT_D;
            r_we        <= 1'b0;
            r_last_gnt  <= c_GNT_I;
            r_cnt       <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_d_rdata   <= '0;
            r_i_rdata   <= '0;
            r_d_done    <= 1'b0;
            r_i_done    <= 1'b0;
            r_d_err     <= 1'b0;
            r_i_err     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_we        <= w_we_nxt;
            r_last_gnt  <= w_last_gnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_done    <= w_d_done_nxt;
            r_i_done    <= w_i_done_nxt;
            r_d_err     <= w_d_err_nxt;
            r_i_err     <= w_i_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_any_req) w_state_nxt = c_BUSY;
            c_BUSY:  if (mem_ready || w_timeout) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Next values for the registered outputs and the latched request
    always_comb begin
        w_gnt_nxt       = r_gnt;
        w_we_nxt        = r_we;
        w_last_gnt_nxt  = r_last_gnt;
        w_cnt_nxt       = r_cnt;
        w_mem_rd_nxt    = r_mem_rd;
        w_mem_wr_nxt    = r_mem_wr;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_i_rdata_nxt   = r_i_rdata;
        w_d_done_nxt    = 1'b0;
        w_i_done_nxt    = 1'b0;
        w_d_err_nxt     = 1'b0;
        w_i_err_nxt     = 1'b0;
        w_busy_nxt      = (w_state_nxt != c_IDLE);
        case (r_state)
            c_IDLE: begin
                if (w_any_req) begin
                    w_gnt_nxt       = w_pick_i;
                    w_last_gnt_nxt  = w_pick_i;
                    w_we_nxt        = w_new_we;
                    w_mem_rd_nxt    = ~w_new_we;
                    w_mem_wr_nxt    = w_new_we;
                    w_mem_addr_nxt  = (w_pick_i ? i_addr : d_addr) & c_LINE_MASK;
                    w_mem_wdata_nxt = w_new_we ? d_wdata : '0;
                    w_cnt_nxt       = '0;
                end
            end
            c_BUSY: begin
                if (mem_ready) begin
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                    if (!r_we) begin
                        if (r_gnt == c_GNT_I) w_i_rdata_nxt = mem_rdata;
                        else                  w_d_rdata_nxt = mem_rdata;
                    end
                    w_i_done_nxt = (r_gnt == c_GNT_I);
                    w_d_done_nxt = (r_gnt == c_GNT_D);
                end else if (w_timeout) begin
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                    w_i_done_nxt = (r_gnt == c_GNT_I);
                    w_d_done_nxt = (r_gnt == c_GNT_D);
                    w_i_err_nxt  = (r_gnt == c_GNT_I);
                    w_d_err_nxt  = (r_gnt == c_GNT_D);
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign d_rdata   = r_d_rdata;
    assign i_rdata   = r_i_rdata;
    assign d_done    = r_d_done;
    assign i_done    = r_i_done;
    assign d_err     = r_d_err;
    assign i_err     = r_i_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter: stimulus pushes expected
//                completions, a monitor pops and compares on every done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_AW = 32;
    localparam int c_LW = 128;
    localparam int c_TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            d_req, d_we, i_req;
    logic [c_AW-1:0] d_addr, i_addr;
    logic [c_LW-1:0] d_wdata, d_rdata, i_rdata;
    logic            d_done, d_err, i_done, i_err;
    logic            mem_rd, mem_wr, mem_ready;
    logic [c_AW-1:0] mem_addr;
    logic [c_LW-1:0] mem_wdata, mem_rdata;
    logic            busy;

    typedef struct {
        bit              port;   // 0 = data, 1 = instr
        bit              err;
        logic [c_LW-1:0] rdata;
    } exp_t;

    exp_t            sbq[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [c_LW-1:0] exp_d_rdata = '0;
    logic [c_LW-1:0] exp_i_rdata = '0;
    bit              resp_en  = 1'b0;
    int              ready_delay = 0;
    int              wait_cnt = 0;
    int              strobes;

    mem_arbiter #(.ADDR_W(c_AW), .LINE_W(c_LW), .TIMEOUT(c_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_done(i_done), .i_err(i_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory contents model: a line's data is a function of its address
    function automatic logic [c_LW-1:0] mem_fn(input logic [c_AW-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'h0BAD_F00D};
    endfunction

    function automatic logic [c_AW-1:0] align(input logic [c_AW-1:0] a);
        return {a[c_AW-1:4], 4'h0};
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    task automatic check(input string name, input logic [c_LW-1:0] act,
                         input logic [c_LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: raises mem_ready after ready_delay extra strobe cycles
    always @(negedge clk) begin
        if (resp_en) begin
            mem_ready = 1'b0;
            if (mem_rd || mem_wr) begin
                if (wait_cnt >= ready_delay) begin
                    mem_ready = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("err_only_with_done",
                  {127'd0, (d_err & ~d_done) | (i_err & ~i_done)}, '0);
            if (d_done || i_done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", {126'd0, i_done, d_done}, '0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("done_onehot", {127'd0, d_done & i_done}, '0);
                    check("done_port", {127'd0, i_done}, {127'd0, e.port});
                    check("done_err", {127'd0, i_done ? i_err : d_err},
                          {127'd0, e.err});
                    check("done_rdata", i_done ? i_rdata : d_rdata, e.rdata);
                end
            end
        end
    end

    // Wait for completion on a port, checking the memory strobes meanwhile
    task automatic wait_done(input bit port, input logic [c_AW-1:0] exp_addr,
                             input bit exp_wr, input logic [c_LW-1:0] exp_wdata,
                             output int n_strb);
        bit seen = 1'b0;
        n_strb = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (mem_rd || mem_wr) begin
                n_strb++;
                if (n_strb == 1) begin
                    check("mem_addr", {96'd0, mem_addr}, {96'd0, exp_addr});
                    check("mem_dir", {126'd0, mem_rd, mem_wr},
                          {126'd0, ~exp_wr, exp_wr});
                    check("mem_wdata", mem_wdata, exp_wdata);
                    check("busy_in_access", {127'd0, busy}, {127'd0, 1'b1});
                end
            end
            if ((port == 1'b0 && d_done) || (port == 1'b1 && i_done)) seen = 1'b1;
        end
        if (!seen) check("done_timeout", '0, {127'd0, 1'b1});
    endtask

    initial begin
        rst_n = 1'b0; d_req = 0; d_we = 0; i_req = 0; mem_ready = 0;
        d_addr = '0; i_addr = '0; d_wdata = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_strobes", {126'd0, mem_rd, mem_wr}, '0);
        check("rst_busy_done", {125'd0, busy, d_done, i_done}, '0);
        check("rst_addr", {96'd0, mem_addr}, '0);
        check("rst_rdata", d_rdata | i_rdata, '0);
        tick();
        rst_n = 1'b1;

        // Simultaneous requests: data first (last_grant resets to instr)
        resp_en = 1'b1; ready_delay = 0;
        d_req = 1; d_we = 0; d_addr = 32'h0000_2008;
        i_req = 1; i_addr = 32'h0000_3014;
        exp_d_rdata = mem_fn(align(32'h0000_2008));
        exp_i_rdata = mem_fn(align(32'h0000_3014));
        sbq.push_back('{1'b0, 1'b0, exp_d_rdata});
        sbq.push_back('{1'b1, 1'b0, exp_i_rdata});
        wait_done(1'b0, 32'h0000_2000, 1'b0, '0, strobes);
        check("min_latency_strobes", strobes, 1);
        tick(); d_req = 0;
        wait_done(1'b1, 32'h0000_3010, 1'b0, '0, strobes);
        tick(); i_req = 0;

        // Second simultaneous pair: data wins again
        d_req = 1; d_addr = 32'h0000_4020; i_req = 1; i_addr = 32'h0000_5030;
        exp_d_rdata = mem_fn(32'h0000_4020);
        exp_i_rdata = mem_fn(32'h0000_5030);
        sbq.push_back('{1'b0, 1'b0, exp_d_rdata});
        sbq.push_back('{1'b1, 1'b0, exp_i_rdata});
        wait_done(1'b0, 32'h0000_4020, 1'b0, '0, strobes);
        tick(); d_req = 0;
        wait_done(1'b1, 32'h0000_5030, 1'b0, '0, strobes);
        tick(); i_req = 0;

        // Single data read, mem_ready after 3 strobe cycles
        ready_delay = 2;
        d_req = 1; d_we = 0; d_addr = 32'h0000_1234;
        exp_d_rdata = mem_fn(32'h0000_1230);
        sbq.push_back('{1'b0, 1'b0, exp_d_rdata});
        wait_done(1'b0, 32'h0000_1230, 1'b0, '0, strobes);
        check("read_strobe_cycles", strobes, 3);
        tick(); d_req = 0;

        // Data write: d_rdata must stay unchanged
        ready_delay = 1;
        d_req = 1; d_we = 1; d_addr = 32'h0000_6047;
        d_wdata = 128'hDEADBEEF_00000000_00000000_00000001;
        sbq.push_back('{1'b0, 1'b0, exp_d_rdata});
        wait_done(1'b0, 32'h0000_6040, 1'b1,
                  128'hDEADBEEF_00000000_00000000_00000001, strobes);
        check("write_strobe_cycles", strobes, 2);
        tick(); d_req = 0; d_we = 0;

        // Timeout on an instruction read
        resp_en = 1'b0; mem_ready = 1'b0;
        i_req = 1; i_addr = 32'h0000_ABCD;
        sbq.push_back('{1'b1, 1'b1, exp_i_rdata});
        wait_done(1'b1, 32'h0000_ABC0, 1'b0, '0, strobes);
        check("timeout_strobe_cycles", strobes, c_TO);
        tick(); i_req = 0;
        @(negedge clk);
        check("done_one_cycle", {126'd0, d_done, i_done}, '0);

        // Stray mem_ready in IDLE
        tick(); mem_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("stray_no_busy", {125'd0, busy, mem_rd, mem_wr}, '0);
        check("stray_d_rdata", d_rdata, exp_d_rdata);
        check("stray_i_rdata", i_rdata, exp_i_rdata);
        mem_ready = 1'b0;

        // Reset in the middle of an access
        tick();
        d_req = 1; d_addr = 32'h0000_4000;
        tick(); d_req = 0;
        tick(); tick();
        @(negedge clk);
        check("pre_reset_busy", {126'd0, busy, mem_rd}, {126'd0, 2'b11});
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_strobes_busy", {125'd0, busy, mem_rd, mem_wr}, '0);
        check("abort_no_done", {126'd0, d_done, i_done}, '0);
        tick(); rst_n = 1'b1;
        exp_d_rdata = '0; exp_i_rdata = '0;
        repeat (3) tick();
        @(negedge clk);
        check("post_reset_rdata", d_rdata | i_rdata, '0);

        // Access after the aborted one completes normally
        resp_en = 1'b1; ready_delay = 1;
        tick();
        d_req = 1; d_addr = 32'h0000_5678;
        exp_d_rdata = mem_fn(32'h0000_5670);
        sbq.push_back('{1'b0, 1'b0, exp_d_rdata});
        wait_done(1'b0, 32'h0000_5670, 1'b0, '0, strobes);
        tick(); d_req = 0;
        repeat (4) tick();

        check("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
